// File: rtl/max_result_reader_pkg.sv
// Widths of the max-score record and the derived beat geometry for the result reader.
// The record is score, then row, then col, and is zero-padded at the MSB to a whole number of beats.
package design_variables;
   localparam int SCORE_WIDTH    = 12;
   localparam int ROW_BITS_WIDTH = 6;
   localparam int COL_BITS_WIDTH = 6;
   localparam int OUT_WIDTH      = 8;

   localparam int REC_W     = SCORE_WIDTH + ROW_BITS_WIDTH + COL_BITS_WIDTH;
   localparam int NUM_BEATS = (REC_W + OUT_WIDTH - 1) / OUT_WIDTH;
   localparam int PAD_W     = NUM_BEATS * OUT_WIDTH;
   localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } rd_state_t;
endpackage

// File: rtl/max_result_reader_piso_shift_reg.sv
// Parallel-in serial-out register for the padded record; beat 0 sits in the top OUT_WIDTH bits.
// A load takes priority over a shift in the same cycle.
module piso_shift_reg
   import design_variables::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_load,
   input  logic                 i_shift,
   input  logic [PAD_W-1:0]     i_data,
   output logic [OUT_WIDTH-1:0] o_top
);
   logic [PAD_W-1:0] r_shift;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift <= '0;
      end else if (i_load) begin
         r_shift <= i_data;
      end else if (i_shift) begin
         r_shift <= r_shift << OUT_WIDTH;
      end
   end

   assign o_top = r_shift[PAD_W-1 -: OUT_WIDTH];
endmodule

// File: rtl/max_result_reader.sv
// Captures the final max-score record on done_in and streams it MSB-first as
// OUT_WIDTH-wide valid/ready beats, with sticky detection of records dropped while busy.
module max_result_reader
   import design_variables::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      done_in,
   input  logic [SCORE_WIDTH-1:0]    max_score,
   input  logic [ROW_BITS_WIDTH-1:0] max_row,
   input  logic [COL_BITS_WIDTH-1:0] max_col,
   output logic [OUT_WIDTH-1:0]      out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_last,
   output logic                      busy,
   output logic                      sent,
   output logic                      drop_err
);
   rd_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_out_valid;
   logic             r_busy;
   logic             r_sent;
   logic             r_drop_err;

   logic             w_capture;
   logic             w_xfer;
   logic             w_cnt_last;
   logic             w_load;
   logic [PAD_W-1:0] w_load_data;

   // start outranks both capture and transfer; a capture is legal only when not streaming
   assign w_capture   = !start && done_in && (r_state != SEND);
   assign w_xfer      = !start && (r_state == SEND) && r_out_valid && out_ready;
   assign w_cnt_last  = (r_cnt == CNT_W'(NUM_BEATS - 1));
   assign w_load      = start || w_capture;
   assign w_load_data = start ? '0 : PAD_W'({max_score, max_row, max_col});

   piso_shift_reg u_piso (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_shift (w_xfer),
      .i_data  (w_load_data),
      .o_top   (out_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_sent      <= 1'b0;
         r_drop_err  <= 1'b0;
      end else if (start) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_sent      <= 1'b0;
         r_drop_err  <= 1'b0;
      end else begin
         r_sent <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (w_capture) begin
                  r_state     <= SEND;
                  r_cnt       <= '0;
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            SEND: begin
               if (done_in) begin
                  r_drop_err <= 1'b1;
               end
               if (w_xfer) begin
                  if (w_cnt_last) begin
                     r_state     <= DONE;
                     r_cnt       <= '0;
                     r_out_valid <= 1'b0;
                     r_busy      <= 1'b0;
                     r_sent      <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               r_state     <= IDLE;
               r_cnt       <= '0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_last  = r_out_valid && w_cnt_last;
   assign busy      = r_busy;
   assign sent      = r_sent;
   assign drop_err  = r_drop_err;
endmodule
